// File: rtl/pipe_ctrl_pkg.sv
// Shared type definitions for the pipeline control slice.
// cpu_types_pkg carries register-index types; diaosi_types_pkg carries
// the next-PC select encoding and the sequencer state type.

package cpu_types_pkg;
    localparam int REG_W = 5;
    typedef logic [REG_W-1:0] regbits_t;
endpackage

package diaosi_types_pkg;
    // Next-PC select carried down the pipe to MEM. Only ADD4 is sequential.
    typedef enum logic [1:0] {
        ADD4_DIAOSI   = 2'd0,
        BRANCH_DIAOSI = 2'd1,
        JUMP_DIAOSI   = 2'd2,
        JR_DIAOSI     = 2'd3
    } pcsrc_diaosi_t;

    typedef enum logic {PCTRL_RUN, PCTRL_HALT} pctrl_state_t;
endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// Load-use hazard detect: the load sitting in ID/EX writes a register that
// the instruction in ID reads. Register 0 never creates a hazard.

module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_d_ren,
    input  regbits_t idex_wsel,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     lu
);
    logic w_nonzero;
    logic w_match;

    assign w_nonzero = (idex_wsel != '0);
    assign w_match   = (idex_wsel == ifid_rs) | (idex_wsel == ifid_rt);
    assign lu        = idex_d_ren & w_nonzero & w_match;
endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: per-register enables/flushes, PC enable,
// gated memory requests, halt tracking and a stalled-cycle counter.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   PCTRL_RUN  | pipeline live; advances when fetch and MEM access are ok
//   PCTRL_HALT | halt retired through MEM; everything frozen until reset
//
// The done-latches remember a memory half that finished while the other
// half was still waiting, so that access is not requested again.

module pipe_ctrl
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
(
    input  logic          CLK,
    input  logic          nRST,
    input  logic          ihit,
    input  logic          dhit,
    input  logic          d_ren_o3,
    input  logic          d_wen_o3,
    input  pcsrc_diaosi_t PCSrc_o3,
    input  logic          halt_o3,
    input  logic          idex_d_ren,
    input  regbits_t      idex_wsel,
    input  regbits_t      ifid_rs,
    input  regbits_t      ifid_rt,
    output logic          pc_en,
    output logic          pipe1_en,
    output logic          pipe2_en,
    output logic          pipe3_en,
    output logic          pipe4_en,
    output logic          flushed1,
    output logic          flushed2,
    output logic          flushed3,
    output logic          imemREN,
    output logic          dmemREN,
    output logic          dmemWEN,
    output logic          halted,
    output logic [15:0]   stall_cnt
);
    pctrl_state_t r_state;
    logic         r_ifetch_done;
    logic         r_dmem_done;
    logic [15:0]  r_stall_cnt;

    logic w_run;
    logic w_mem_req;
    logic w_fetch_ok;
    logic w_mem_ok;
    logic w_advance;
    logic w_redirect;
    logic w_lu;

    load_use_detect u_lu (
        .idex_d_ren (idex_d_ren),
        .idex_wsel  (idex_wsel),
        .ifid_rs    (ifid_rs),
        .ifid_rt    (ifid_rt),
        .lu         (w_lu)
    );

    assign w_run      = (r_state == PCTRL_RUN);
    assign w_mem_req  = d_ren_o3 | d_wen_o3;
    assign w_fetch_ok = ihit | r_ifetch_done;
    assign w_mem_ok   = ~w_mem_req | dhit | r_dmem_done;
    assign w_advance  = w_run & w_fetch_ok & w_mem_ok;
    assign w_redirect = (PCSrc_o3 != ADD4_DIAOSI);

    assign imemREN   = w_run & ~r_ifetch_done;
    assign dmemREN   = w_run & d_ren_o3 & ~r_dmem_done;
    assign dmemWEN   = w_run & d_wen_o3 & ~r_dmem_done;
    assign halted    = (r_state == PCTRL_HALT);
    assign stall_cnt = r_stall_cnt;

    // Enable/flush strobes: redirect beats load-use; load-use freezes PC
    // and IF/ID and injects a bubble into ID/EX.
    always_comb begin
        pc_en    = 1'b0;
        pipe1_en = 1'b0;
        pipe2_en = 1'b0;
        pipe3_en = 1'b0;
        pipe4_en = 1'b0;
        flushed1 = 1'b0;
        flushed2 = 1'b0;
        flushed3 = 1'b0;
        if (w_advance) begin
            pipe2_en = 1'b1;
            pipe3_en = 1'b1;
            pipe4_en = 1'b1;
            if (w_redirect) begin
                pc_en    = 1'b1;
                pipe1_en = 1'b1;
                flushed1 = 1'b1;
                flushed2 = 1'b1;
                flushed3 = 1'b1;
            end else if (w_lu) begin
                flushed2 = 1'b1;
            end else begin
                pc_en    = 1'b1;
                pipe1_en = 1'b1;
            end
        end
    end

    // Run/halt state: halt is taken only when the halting instruction advances.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_state <= PCTRL_RUN;
        else if (w_advance && halt_o3)
            r_state <= PCTRL_HALT;
    end

    // Done-latches: hold a completed half of a stalled cycle until advance.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_ifetch_done <= 1'b0;
            r_dmem_done   <= 1'b0;
        end else if (w_advance) begin
            r_ifetch_done <= 1'b0;
            r_dmem_done   <= 1'b0;
        end else begin
            if (ihit)
                r_ifetch_done <= 1'b1;
            if (dhit && w_mem_req)
                r_dmem_done <= 1'b1;
        end
    end

    // Saturating count of cycles spent stalled while running.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_stall_cnt <= '0;
        else if (w_run && !w_advance && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle vectors applied
// right after reset, plus hand-written multi-cycle sequences.

module tb_pipe_ctrl;
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, dhit, d_ren_o3, d_wen_o3, halt_o3, idex_d_ren;
    pcsrc_diaosi_t PCSrc_o3;
    regbits_t      idex_wsel, ifid_rs, ifid_rt;
    logic          pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en;
    logic          flushed1, flushed2, flushed3;
    logic          imemREN, dmemREN, dmemWEN, halted;
    logic [15:0]   stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .d_ren_o3(d_ren_o3), .d_wen_o3(d_wen_o3), .PCSrc_o3(PCSrc_o3),
        .halt_o3(halt_o3), .idex_d_ren(idex_d_ren), .idex_wsel(idex_wsel),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .pc_en(pc_en),
        .pipe1_en(pipe1_en), .pipe2_en(pipe2_en), .pipe3_en(pipe3_en),
        .pipe4_en(pipe4_en), .flushed1(flushed1), .flushed2(flushed2),
        .flushed3(flushed3), .imemREN(imemREN), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Output bit order: {pc,p1,p2,p3,p4, f1,f2,f3, imem,dren,dwen}
    localparam logic [10:0] O_ZERO  = 11'b00000_000_000;
    localparam logic [10:0] O_IDLE  = 11'b00000_000_100;
    localparam logic [10:0] O_RUN   = 11'b11111_000_100;
    localparam logic [10:0] O_LU    = 11'b00111_010_100;
    localparam logic [10:0] O_REDIR = 11'b11111_111_100;

    typedef struct {
        string         name;
        logic          ihit, dhit, d_ren, d_wen, halt, idex_d_ren;
        logic [4:0]    wsel, rs, rt;
        pcsrc_diaosi_t pcsrc;
        logic [10:0]   exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] outs();
        return {pc_en, pipe1_en, pipe2_en, pipe3_en, pipe4_en,
                flushed1, flushed2, flushed3, imemREN, dmemREN, dmemWEN};
    endfunction

    task automatic chk_outs(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = outs();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_val(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic ih, input logic dh,
                           input logic dr, input logic dw, input logic hl,
                           input logic ldr, input logic [4:0] ws, input logic [4:0] rs,
                           input logic [4:0] rt, input pcsrc_diaosi_t pc,
                           input logic [10:0] exp);
        vec_t v;
        v.name = name; v.ihit = ih; v.dhit = dh; v.d_ren = dr; v.d_wen = dw;
        v.halt = hl; v.idex_d_ren = ldr; v.wsel = ws; v.rs = rs; v.rt = rt;
        v.pcsrc = pc; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        ihit = 0; dhit = 0; d_ren_o3 = 0; d_wen_o3 = 0; halt_o3 = 0;
        idex_d_ren = 0; idex_wsel = 0; ifid_rs = 0; ifid_rt = 0;
        PCSrc_o3 = ADD4_DIAOSI;
    endtask

    // Async reset pulse placed between clock edges.
    task automatic pulse_reset();
        nRST = 0;
        #1;
        nRST = 1;
    endtask

    // Move to 1 time unit after the next rising edge (start of a new cycle).
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        idle_inputs();
        nRST = 0;
        #1;
        chk_outs("reset_outputs", O_IDLE);
        chk_val("reset_halted", {15'd0, halted}, 16'd0);
        chk_val("reset_stall_cnt", stall_cnt, 16'd0);

        // Single-cycle table, each applied straight after a reset.
        add_vec("idle_hit",       1,0,0,0,0,0, 0,0,0, ADD4_DIAOSI,   O_RUN);
        add_vec("no_ihit",        0,0,0,0,0,0, 0,0,0, ADD4_DIAOSI,   O_IDLE);
        add_vec("load_wait",      1,0,1,0,0,0, 0,0,0, ADD4_DIAOSI,   11'b00000_000_110);
        add_vec("load_hit",       1,1,1,0,0,0, 0,0,0, ADD4_DIAOSI,   11'b11111_000_110);
        add_vec("store_hit",      1,1,0,1,0,0, 0,0,0, ADD4_DIAOSI,   11'b11111_000_101);
        add_vec("store_wait",     1,0,0,1,0,0, 0,0,0, ADD4_DIAOSI,   11'b00000_000_101);
        add_vec("dhit_no_req",    0,1,0,0,0,0, 0,0,0, ADD4_DIAOSI,   O_IDLE);
        add_vec("lu_rs",          1,0,0,0,0,1, 5,5,3, ADD4_DIAOSI,   O_LU);
        add_vec("lu_rt",          1,0,0,0,0,1, 5,2,5, ADD4_DIAOSI,   O_LU);
        add_vec("lu_wsel0",       1,0,0,0,0,1, 0,0,0, ADD4_DIAOSI,   O_RUN);
        add_vec("lu_no_load",     1,0,0,0,0,0, 7,7,7, ADD4_DIAOSI,   O_RUN);
        add_vec("lu_no_match",    1,0,0,0,0,1, 9,8,10, ADD4_DIAOSI,  O_RUN);
        add_vec("redirect",       1,0,0,0,0,0, 0,0,0, BRANCH_DIAOSI, O_REDIR);
        add_vec("redirect_lu",    1,0,0,0,0,1, 5,0,5, JUMP_DIAOSI,   O_REDIR);
        add_vec("redirect_stall", 0,0,0,0,0,0, 0,0,0, JR_DIAOSI,     O_IDLE);
        add_vec("redir_ld_wait",  1,0,1,0,0,0, 0,0,0, BRANCH_DIAOSI, 11'b00000_000_110);
        add_vec("halt_advance",   1,0,0,0,1,0, 0,0,0, ADD4_DIAOSI,   O_RUN);

        for (int i = 0; i < vecs.size(); i++) begin
            next_cycle();
            idle_inputs();
            pulse_reset();
            ihit = vecs[i].ihit; dhit = vecs[i].dhit;
            d_ren_o3 = vecs[i].d_ren; d_wen_o3 = vecs[i].d_wen;
            halt_o3 = vecs[i].halt; idex_d_ren = vecs[i].idex_d_ren;
            idex_wsel = vecs[i].wsel; ifid_rs = vecs[i].rs; ifid_rt = vecs[i].rt;
            PCSrc_o3 = vecs[i].pcsrc;
            #1;
            chk_outs(vecs[i].name, vecs[i].exp);
        end

        // Free-running fetch with no memory traffic.
        next_cycle();
        idle_inputs();
        pulse_reset();
        ihit = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk_outs("free_run", O_RUN);
            next_cycle();
        end
        chk_val("free_run_stall_cnt", stall_cnt, 16'd0);

        // Load: ihit in cycle 0, dhit in cycle 3.
        idle_inputs();
        pulse_reset();
        d_ren_o3 = 1; ihit = 1;
        #1;
        chk_outs("ld_c0", 11'b00000_000_110);
        next_cycle();
        ihit = 0;
        #1;
        chk_outs("ld_c1", 11'b00000_000_010);
        next_cycle();
        #1;
        chk_outs("ld_c2", 11'b00000_000_010);
        next_cycle();
        dhit = 1;
        #1;
        chk_outs("ld_c3_advance", 11'b11111_000_010);
        chk_val("ld_c3_stall_cnt", stall_cnt, 16'd3);
        next_cycle();
        dhit = 0;
        #1;
        chk_outs("ld_after", 11'b00000_000_110);
        chk_val("ld_after_stall_cnt", stall_cnt, 16'd3);

        // dhit first in cycle 0, ihit in cycle 2.
        idle_inputs();
        pulse_reset();
        d_ren_o3 = 1; dhit = 1;
        #1;
        chk_outs("dfirst_c0", 11'b00000_000_110);
        next_cycle();
        dhit = 0;
        #1;
        chk_outs("dfirst_c1", 11'b00000_000_100);
        next_cycle();
        ihit = 1;
        #1;
        chk_outs("dfirst_c2_advance", 11'b11111_000_100);
        chk_val("dfirst_stall_cnt", stall_cnt, 16'd2);
        next_cycle();
        ihit = 0;
        #1;
        chk_outs("dfirst_reissue", 11'b00000_000_110);

        // Load-use for exactly one cycle, then the bubble clears ID/EX.
        idle_inputs();
        pulse_reset();
        ihit = 1; idex_d_ren = 1; idex_wsel = 5; ifid_rt = 5;
        #1;
        chk_outs("lu_seq_c0", O_LU);
        next_cycle();
        idex_d_ren = 0;
        #1;
        chk_outs("lu_seq_c1", O_RUN);

        // Reset mid-stall clears both latches at once.
        idle_inputs();
        pulse_reset();
        ihit = 1; d_ren_o3 = 1;
        next_cycle();
        ihit = 0; dhit = 0;
        #1;
        chk_outs("midstall_latched", 11'b00000_000_010);
        nRST = 0;
        #1;
        chk_outs("midstall_reset", 11'b00000_000_110);
        chk_val("midstall_reset_cnt", stall_cnt, 16'd0);
        nRST = 1;

        // Halt retires, then everything freezes until reset.
        next_cycle();
        idle_inputs();
        pulse_reset();
        ihit = 1; halt_o3 = 1;
        #1;
        chk_val("halt_c0_halted", {15'd0, halted}, 16'd0);
        next_cycle();
        halt_o3 = 0; d_ren_o3 = 1; d_wen_o3 = 1; dhit = 1;
        #1;
        chk_outs("halt_outputs", O_ZERO);
        chk_val("halt_halted", {15'd0, halted}, 16'd1);
        ihit = 0; dhit = 0;
        for (int c = 0; c < 3; c++) next_cycle();
        chk_val("halt_sticky", {15'd0, halted}, 16'd1);
        chk_val("halt_stall_hold", stall_cnt, 16'd0);
        ihit = 1; dhit = 1;
        #1;
        chk_outs("halt_outputs_late", O_ZERO);
        nRST = 0;
        #1;
        chk_val("halt_reset_cleared", {15'd0, halted}, 16'd0);
        nRST = 1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
